// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, FSM state type and the
// clocks-per-bit helper used by both the receive and transmit paths.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEF_BAUD_RATE = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clocks per bit period (integer division, truncating).
    function automatic int unsigned calc_baud_cnt(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rxd.sv
// UART 8N1 receiver (idle high, LSB first) with 3-sample majority voting,
// start-bit glitch rejection and framing-error detection.
//   SYS_CLK   : system clock
//   RST_N     : synchronous active-low reset
//   Rxd       : asynchronous serial input, idle high
//   data_out  : last correctly received byte, held until the next good frame
//   rx_done   : one-cycle pulse, data_out newly updated
//   frame_err : one-cycle pulse, stop bit sampled low
//   rx_busy   : high from start-edge detection until the stop-bit decision
// CLK_FREQ / BAUD_RATE must be at least 8.
module uart_rxd
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic       Rxd,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W    = $clog2(BAUD_CNT);
    localparam int unsigned HALF     = BAUD_CNT / 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic             rxd_s1;
    logic             rxd_s2;
    logic             rxd_prev;
    uart_state_t      state,    state_n;
    logic [CNT_W-1:0] cnt,      cnt_n;
    logic [2:0]       bit_idx,  bit_idx_n;
    logic [7:0]       shift,    shift_n;
    logic [1:0]       samp,     samp_n;
    logic [7:0]       data_n;
    logic             done_n;
    logic             err_n;
    logic             busy_n;
    logic             fall;
    logic             cnt_wrap;
    logic             decide;
    logic             bit_val;

    // Two-stage synchronizer plus previous-value register for edge detection.
    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= Rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign fall     = rxd_prev & ~rxd_s2;
    assign cnt_wrap = (cnt == CNT_W'(BAUD_CNT - 1));
    assign decide   = (cnt == CNT_W'(HALF + 1));
    // Third sample is the live synchronized value at the decision point.
    assign bit_val  = maj3(samp[0], samp[1], rxd_s2);

    // State and datapath registers.
    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            samp      <= '0;
            data_out  <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            samp      <= samp_n;
            data_out  <= data_n;
            rx_done   <= done_n;
            frame_err <= err_n;
            rx_busy   <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        samp_n    = samp;
        data_n    = data_out;
        done_n    = 1'b0;
        err_n     = 1'b0;
        busy_n    = rx_busy;

        if (state != IDLE) begin
            cnt_n = cnt_wrap ? '0 : CNT_W'(cnt + 1'b1);
            if (cnt == CNT_W'(HALF - 1)) samp_n[0] = rxd_s2;
            if (cnt == CNT_W'(HALF))     samp_n[1] = rxd_s2;
        end

        case (state)
            IDLE: begin
                // Only a fresh falling edge starts a frame; a held-low line does not.
                if (fall) begin
                    state_n = START;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                end else if (cnt_wrap) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (decide) shift_n = {bit_val, shift[7:1]};
                if (cnt_wrap) begin
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = 3'(bit_idx + 1'b1);
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (decide) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    if (bit_val) begin
                        data_n = shift;
                        done_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
